// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell (two half adders + OR) steps
// LSB-first through WIDTH-bit operands. Optional: SERIAL_ADDER_SUB_EN.

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SUB,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             BUSY,
    output logic             DONE
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic           carry_q;
    logic [CW-1:0]  cnt_q;

    logic b_bit;
    logic carry_init;
    logic s0;
    logic c0;
    logic c1;
    logic fa_s;
    logic fa_c;

`ifdef SERIAL_ADDER_SUB_EN
    logic sub_q;
    assign b_bit      = b_q[0] ^ sub_q;
    assign carry_init = SUB;
`else
    logic unused_sub;
    assign unused_sub = SUB;
    assign b_bit      = b_q[0];
    assign carry_init = 1'b0;
`endif

    half_adder u_ha0 (
        .a (a_q[0]),
        .b (b_bit),
        .s (s0),
        .c (c0)
    );

    half_adder u_ha1 (
        .a (s0),
        .b (carry_q),
        .s (fa_s),
        .c (c1)
    );

    assign fa_c = c0 | c1;

    // Control FSM plus serial datapath; every output is a register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            SUM     <= '0;
            COUT    <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            DONE <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (START) begin
                        a_q     <= A;
                        b_q     <= B;
                        carry_q <= carry_init;
                        cnt_q   <= '0;
                        BUSY    <= 1'b1;
                        state   <= S_RUN;
`ifdef SERIAL_ADDER_SUB_EN
                        sub_q   <= SUB;
`endif
                    end
                end
                S_RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    res_q   <= {fa_s, res_q[WIDTH-1:1]};
                    carry_q <= fa_c;
                    cnt_q   <= cnt_q + 1'b1;
                    // Last bit: publish the completed word and carry.
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        SUM   <= {fa_s, res_q[WIDTH-1:1]};
                        COUT  <= fa_c;
                        DONE  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed vectors plus
// randomized operations against an arithmetic reference model.

module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] prev_sum;
    logic         prev_cout;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .START (start),
        .A     (a),
        .B     (b),
        .SUB   (sub),
        .SUM   (sum),
        .COUT  (cout),
        .BUSY  (busy),
        .DONE  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain W+1-bit arithmetic; top bit is the carry out.
    function automatic logic [W:0] ref_op(input logic [W-1:0] x,
                                          input logic [W-1:0] y,
                                          input logic s);
        logic [W:0] r;
        r = {1'b0, x} + {1'b0, y};
`ifdef SERIAL_ADDER_SUB_EN
        if (s)
            r = {1'b0, x} + {1'b0, ~y} + 1;
`endif
        return r;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge
    // one cycle after the DONE cycle (DUT back in IDLE).
    task automatic do_op(input string tag, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic s,
                         input logic hold, input logic [W:0] exp);
        int edges;
        int busy_cnt;
        a     = x;
        b     = y;
        sub   = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        a   = W'($urandom);
        b   = W'($urandom);
        sub = 1'($urandom);
        edges    = 0;
        busy_cnt = 0;
        @(negedge clk);
        while (!done && edges < W + 4) begin
            if (busy) busy_cnt++;
            if (edges == W / 2)
                check({tag, "_held"}, {cout, sum}, {prev_cout, prev_sum});
            @(negedge clk);
            edges++;
        end
        check({tag, "_lat"}, 64'(edges), 64'(W));
        if (busy) busy_cnt++;
        check({tag, "_sum"}, 64'(sum), 64'(exp[W-1:0]));
        check({tag, "_cout"}, 64'(cout), 64'(exp[W]));
        prev_sum  = exp[W-1:0];
        prev_cout = exp[W];
        @(negedge clk);
        check({tag, "_done1"}, 64'(done), 64'(0));
        check({tag, "_busyoff"}, 64'(busy), 64'(0));
        check({tag, "_busycnt"}, 64'(busy_cnt), 64'(W + 1));
        check({tag, "_keep"}, {cout, sum}, {prev_cout, prev_sum});
        start = 1'b0;
    endtask

    initial begin
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        logic         rs;
        logic         rh;
        logic [W:0]   e;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        sub   = 1'b0;
        prev_sum  = '0;
        prev_cout = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out", {done, busy, cout, sum}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("d0f01", 8'h0F, 8'h01, 1'b0, 1'b0, 9'h010);
        do_op("dff01", 8'hFF, 8'h01, 1'b0, 1'b0, 9'h100);
        do_op("daa55", 8'hAA, 8'h55, 1'b0, 1'b0, 9'h0FF);

        do_op("hold1", 8'h01, 8'h02, 1'b0, 1'b1, 9'h003);
        do_op("hold2", 8'h33, 8'h44, 1'b0, 1'b0, 9'h077);

`ifdef SERIAL_ADDER_SUB_EN
        do_op("sub57", 8'h05, 8'h07, 1'b1, 1'b0, 9'h0FE);
        do_op("sub75", 8'h07, 8'h05, 1'b1, 1'b0, 9'h102);
`else
        do_op("nosub", 8'h05, 8'h07, 1'b1, 1'b0, 9'h00C);
`endif

        // Abort during the 4th RUN cycle.
        a     = 8'h3C;
        b     = 8'h5A;
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out", {done, busy, cout, sum}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_sum  = '0;
        prev_cout = 1'b0;
        begin
            int dseen;
            dseen = 0;
            repeat (W + 3) begin
                @(negedge clk);
                if (done || busy) dseen++;
            end
            check("abort_quiet", 64'(dseen), 64'(0));
        end
        do_op("post_rst", 8'h10, 8'h20, 1'b0, 1'b0, 9'h030);

        for (int i = 0; i < 25; i++) begin
            rx = W'($urandom);
            ry = W'($urandom);
            rs = 1'($urandom);
            rh = ($urandom_range(0, 3) == 0);
            e  = ref_op(rx, ry, rs);
            do_op($sformatf("rnd%0d", i), rx, ry, rs, rh, e);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
